// File: rtl/opbomp.sv
// Greedy orthogonal pursuit over a 32-atom Walsh-Hadamard dictionary, streamed as serial records.
// Optional macro OPBOMP_COEF_OUT_EN appends each atom's 19-bit coefficient after its sign bit.
module opbomp #(
  parameter int SW    = 12,
  parameter int ITERS = 4,
  parameter int RW    = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [32*SW-1:0] x,
  output logic            output_bits,
  output logic            bit_valid,
  output logic            frame_sync
);

  localparam int CW = 19;
`ifdef OPBOMP_COEF_OUT_EN
  localparam int FL = 6 + CW;
`else
  localparam int FL = 6;
`endif
  localparam int IW  = $clog2(ITERS + 1);
  localparam int PW  = $clog2(FL);
  localparam int RIW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [IW-1:0]  ITERS_V  = IW'(ITERS);
  localparam logic [PW-1:0]  FL_LAST  = PW'(FL - 1);
  localparam logic [RIW-1:0] REC_LAST = RIW'(ITERS - 1);
  localparam logic signed [CW:0] RMAX = (CW+1)'((2 ** (RW - 1)) - 1);
  localparam logic signed [CW:0] RMIN = (CW+1)'(-(2 ** (RW - 1)));

  typedef enum logic [1:0] {LOAD, SCAN, UPDATE, OUT} state_t;

  state_t                state, state_n;
  logic [4:0]            k, k_n;
  logic [IW-1:0]         iter, iter_n;
  logic [RIW-1:0]        orec, orec_n;
  logic [PW-1:0]         opos, opos_n;
  logic signed [RW-1:0]  r [32];
  logic signed [CW-1:0]  corr, best_corr, c_full;
  logic [CW-1:0]         corr_abs, best_abs;
  logic [4:0]            best_idx;
  logic [4:0]            rec_idx [ITERS];
  logic                  rec_sgn [ITERS];
`ifdef OPBOMP_COEF_OUT_EN
  logic signed [CW-1:0]  rec_c [ITERS];
`endif
  logic [FL-1:0]         rec_vec;
  logic                  bit_n;

  // Walsh-Hadamard sign: atom k is negative at sample j when k&j has odd parity.
  function automatic logic h_neg(input logic [4:0] a, input logic [4:0] b);
    return ^(a & b);
  endfunction

  function automatic logic signed [RW-1:0] sat_rw(input logic signed [CW:0] v);
    if (v > RMAX)      return $signed(RMAX[RW-1:0]);
    else if (v < RMIN) return $signed(RMIN[RW-1:0]);
    else               return $signed(v[RW-1:0]);
  endfunction

  function automatic logic signed [RW-1:0] upd(input logic signed [RW-1:0] rv,
                                               input logic signed [CW-1:0] cv,
                                               input logic neg);
    logic signed [CW:0] d;
    d = neg ? ((CW+1)'(rv) + (CW+1)'(cv)) : ((CW+1)'(rv) - (CW+1)'(cv));
    return sat_rw(d);
  endfunction

  always_comb begin
    corr = '0;
    for (int j = 0; j < 32; j++) begin
      if (h_neg(k, 5'(j))) corr = corr - CW'(r[j]);
      else                 corr = corr + CW'(r[j]);
    end
  end

  assign corr_abs = corr[CW-1] ? CW'(-corr) : CW'(corr);
  assign c_full   = best_corr >>> 5;

  always_comb begin
    state_n = state;
    k_n     = k;
    iter_n  = iter;
    orec_n  = orec;
    opos_n  = opos;
    case (state)
      LOAD: begin
        state_n = SCAN;
        k_n     = '0;
        iter_n  = '0;
      end
      SCAN: begin
        k_n = k + 5'd1;
        if (k == 5'd31) state_n = UPDATE;
      end
      UPDATE: begin
        iter_n = iter + 1'b1;
        k_n    = '0;
        if (iter_n < ITERS_V) begin
          state_n = SCAN;
        end else begin
          state_n = OUT;
          orec_n  = '0;
          opos_n  = '0;
        end
      end
      OUT: begin
        if (opos == FL_LAST) begin
          opos_n = '0;
          orec_n = orec + 1'b1;
          if (orec == REC_LAST) state_n = LOAD;
        end else begin
          opos_n = opos + 1'b1;
        end
      end
      default: state_n = LOAD;
    endcase
  end

  // Output bits are registered from the next-cycle position so they align with the OUT state.
  always_comb begin
`ifdef OPBOMP_COEF_OUT_EN
    rec_vec = {rec_idx[orec_n], rec_sgn[orec_n], rec_c[orec_n]};
`else
    rec_vec = {rec_idx[orec_n], rec_sgn[orec_n]};
`endif
    bit_n = rec_vec[FL_LAST - opos_n];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      k           <= '0;
      iter        <= '0;
      orec        <= '0;
      opos        <= '0;
      best_corr   <= '0;
      best_abs    <= '0;
      best_idx    <= '0;
      output_bits <= 1'b0;
      bit_valid   <= 1'b0;
      frame_sync  <= 1'b0;
      for (int j = 0; j < 32; j++) r[j] <= '0;
      for (int i = 0; i < ITERS; i++) begin
        rec_idx[i] <= '0;
        rec_sgn[i] <= 1'b0;
`ifdef OPBOMP_COEF_OUT_EN
        rec_c[i]   <= '0;
`endif
      end
    end else begin
      state       <= state_n;
      k           <= k_n;
      iter        <= iter_n;
      orec        <= orec_n;
      opos        <= opos_n;
      bit_valid   <= (state_n == OUT);
      frame_sync  <= (state_n == OUT) && (orec_n == '0) && (opos_n == '0);
      output_bits <= (state_n == OUT) ? bit_n : 1'b0;
      case (state)
        LOAD: begin
          for (int j = 0; j < 32; j++) r[j] <= RW'($signed(x[SW*j +: SW]));
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties; k=0 seeds the search.
          if (k == 5'd0 || corr_abs > best_abs) begin
            best_abs  <= corr_abs;
            best_corr <= corr;
            best_idx  <= k;
          end
        end
        UPDATE: begin
          for (int j = 0; j < 32; j++) r[j] <= upd(r[j], c_full, h_neg(best_idx, 5'(j)));
          rec_idx[iter[RIW-1:0]] <= best_idx;
          rec_sgn[iter[RIW-1:0]] <= best_corr[CW-1];
`ifdef OPBOMP_COEF_OUT_EN
          rec_c[iter[RIW-1:0]]   <= c_full;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_opbomp.sv
// Bench for opbomp (default build): directed vector table, randomized frames vs. a pursuit model,
// and sequences for frame timing, mid-frame input changes and mid-frame reset.
module tb_opbomp;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [383:0] x   = '0;
  logic         output_bits, bit_valid, frame_sync;

  int ncmp  = 0;
  int nfail = 0;

  opbomp dut (
    .clk(clk), .rst(rst), .x(x),
    .output_bits(output_bits), .bit_valid(bit_valid), .frame_sync(frame_sync)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [383:0] xv;
    logic [23:0]  exp;
  } vec_t;

  vec_t tv [7];

  function automatic int hsign(input int k, input int j);
    return ($countones(k & j) % 2 == 0) ? 1 : -1;
  endfunction

  // Reference: plain-integer greedy pursuit, floor division, clamped residual.
  function automatic logic [23:0] model(input logic [383:0] xv);
    int r [32];
    int best, bk, corr, c, abs_c, abs_b;
    logic [23:0] bits;
    bits = '0;
    for (int j = 0; j < 32; j++) r[j] = int'($signed(xv[12*j +: 12]));
    for (int it = 0; it < 4; it++) begin
      best = 0;
      bk   = 0;
      for (int kk = 0; kk < 32; kk++) begin
        corr = 0;
        for (int j = 0; j < 32; j++) corr += hsign(kk, j) * r[j];
        abs_c = (corr < 0) ? -corr : corr;
        abs_b = (best < 0) ? -best : best;
        if (kk == 0 || abs_c > abs_b) begin
          best = corr;
          bk   = kk;
        end
      end
      c = (best >= 0) ? best / 32 : -((-best + 31) / 32);
      for (int j = 0; j < 32; j++) begin
        r[j] = r[j] - c * hsign(bk, j);
        if (r[j] > 8191)  r[j] = 8191;
        if (r[j] < -8192) r[j] = -8192;
      end
      bits = {bits[17:0], 5'(bk), (best < 0)};
    end
    return bits;
  endfunction

  function automatic logic [383:0] atoms_x(input int a1, input int m1, input int a2, input int m2);
    logic [383:0] v;
    v = '0;
    for (int j = 0; j < 32; j++) v[12*j +: 12] = 12'(m1 * hsign(a1, j) + m2 * hsign(a2, j));
    return v;
  endfunction

  function automatic logic [383:0] rand_x(input int mode);
    logic [383:0] v;
    int a1, a2, m1, m2;
    v  = '0;
    a1 = $urandom_range(0, 31);
    a2 = $urandom_range(0, 31);
    m1 = int'($urandom_range(0, 1800)) - 900;
    m2 = int'($urandom_range(0, 1800)) - 900;
    for (int j = 0; j < 32; j++) begin
      if (mode == 0) v[12*j +: 12] = 12'($urandom_range(0, 4095));
      else v[12*j +: 12] = 12'(m1 * hsign(a1, j) + m2 * hsign(a2, j) + int'($urandom_range(0, 6)) - 3);
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observes up to 'limit' negedges starting with the one after the next LOAD edge.
  task automatic watch_frame(input int limit, input int change_at, input logic [383:0] newx,
                             output int start, output logic [23:0] got,
                             output int nval, output bit sync_ok);
    start   = -1;
    got     = '0;
    nval    = 0;
    sync_ok = 1'b1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (n == change_at) x = newx;
      if (bit_valid) begin
        if (start < 0) start = n;
        if (nval < 24) got = {got[22:0], output_bits};
        if (frame_sync !== (nval == 0)) sync_ok = 1'b0;
        nval++;
      end else begin
        if (frame_sync || output_bits) sync_ok = 1'b0;
        if (start >= 0) break;
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [23:0] exp,
                             input int change_at, input logic [383:0] newx);
    int start, nval;
    logic [23:0] got;
    bit sync_ok;
    watch_frame(400, change_at, newx, start, got, nval, sync_ok);
    check({name, ".start"}, 64'(start), 64'd132);
    check({name, ".bits"},  64'(got),   64'(exp));
    check({name, ".nval"},  64'(nval),  64'd24);
    check({name, ".sync"},  64'(sync_ok), 64'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [383:0] va, vb;

    tv[0] = '{name: "dc100",  xv: atoms_x(0, 100, 0, 0),   exp: 24'h000000};
    tv[1] = '{name: "neg_h3", xv: atoms_x(3, -50, 0, 0),   exp: 24'b000111_000000_000000_000000};
    tv[2] = '{name: "h5_h9",  xv: atoms_x(5, 200, 9, 40),  exp: 24'b001010_010010_000000_000000};
    tv[3] = '{name: "zero",   xv: '0,                      exp: 24'h000000};
    tv[4] = '{name: "tie2_7", xv: atoms_x(2, 100, 7, 100), exp: 24'b000100_001110_000000_000000};
    tv[5] = '{name: "floor",  xv: {{372{1'b0}}, 12'hFFF},  exp: 24'b000001_000000_000000_000000};
    tv[6] = '{name: "min",    xv: atoms_x(0, -2048, 0, 0), exp: 24'b000001_000000_000000_000000};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.bit_valid",   64'(bit_valid),   64'd0);
    check("rst.frame_sync",  64'(frame_sync),  64'd0);
    check("rst.output_bits", 64'(output_bits), 64'd0);

    for (int i = 0; i < 7; i++) begin
      x = tv[i].xv;
      pulse_reset();
      check_frame(tv[i].name, tv[i].exp, -1, '0);
    end

    // Free-running frames: x presented after each stream is captured by the following LOAD.
    x = rand_x(1);
    pulse_reset();
    for (int i = 0; i < 12; i++) begin
      va = x;
      check_frame($sformatf("rand%0d", i), model(va), -1, '0);
      x = rand_x(i % 2);
    end

    // x changed mid-frame affects only the next frame.
    va = rand_x(1);
    vb = rand_x(1);
    x  = va;
    pulse_reset();
    check_frame("xchg.cur", model(va), 50, vb);
    check_frame("xchg.nxt", model(vb), -1, '0);

    // Reset during SCAN of the second iteration.
    x = va;
    pulse_reset();
    repeat (41) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rscan.bit_valid", 64'(bit_valid), 64'd0);
    rst = 1'b0;
    check_frame("rscan.frame", model(va), -1, '0);

    // Reset during OUT aborts the stream immediately.
    x = vb;
    pulse_reset();
    repeat (140) @(negedge clk);
    check("rout.pre_valid", 64'(bit_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rout.bit_valid",  64'(bit_valid),   64'd0);
    check("rout.frame_sync", 64'(frame_sync),  64'd0);
    check("rout.bits",       64'(output_bits), 64'd0);
    rst = 1'b0;
    check_frame("rout.frame", model(vb), -1, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
